// File: rtl/pipe_stall_flush_regs.sv
// rtl/pipe_stall_flush_regs.sv - PC, IF/ID and ID/EX registers with stall/flush control
// and saturating hazard event counters for the 5-stage RV32I core.
module pipe_stall_flush_regs #(
   parameter int                XLEN      = 32,
   parameter int                CTRL_W    = 12,
   parameter logic [XLEN-1:0]   RESET_PC  = '0,
   parameter logic [31:0]       NOP_INSTR = 32'h0000_0013,
   parameter int                CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_f,
   input  logic              stall_d,
   input  logic              flush_d,
   input  logic              flush_e,
   input  logic [XLEN-1:0]   pc_next_f,
   input  logic [31:0]       instr_f,
   input  logic [XLEN-1:0]   pc_plus4_f,
   input  logic [XLEN-1:0]   rd1_d,
   input  logic [XLEN-1:0]   rd2_d,
   input  logic [XLEN-1:0]   imm_ext_d,
   input  logic [4:0]        rs1_d,
   input  logic [4:0]        rs2_d,
   input  logic [4:0]        rd_d,
   input  logic [CTRL_W-1:0] ctrl_d,
   input  logic              cnt_clr,
   output logic [XLEN-1:0]   pc_f,
   output logic [31:0]       instr_d,
   output logic [XLEN-1:0]   pc_d,
   output logic [XLEN-1:0]   pc_plus4_d,
   output logic              valid_d,
   output logic [XLEN-1:0]   rd1_e,
   output logic [XLEN-1:0]   rd2_e,
   output logic [XLEN-1:0]   imm_ext_e,
   output logic [XLEN-1:0]   pc_e,
   output logic [XLEN-1:0]   pc_plus4_e,
   output logic [4:0]        rs1_e,
   output logic [4:0]        rs2_e,
   output logic [4:0]        rd_e,
   output logic [CTRL_W-1:0] ctrl_e,
   output logic              valid_e,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_f <= RESET_PC;
      end else if (!stall_f) begin
         pc_f <= pc_next_f;
      end
   end

   // Flush outranks stall so a redirect never leaves a stale instruction in decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_d    <= NOP_INSTR;
         pc_d       <= '0;
         pc_plus4_d <= '0;
         valid_d    <= 1'b0;
      end else if (flush_d) begin
         instr_d    <= NOP_INSTR;
         pc_d       <= '0;
         pc_plus4_d <= '0;
         valid_d    <= 1'b0;
      end else if (!stall_d) begin
         instr_d    <= instr_f;
         pc_d       <= pc_f;
         pc_plus4_d <= pc_plus4_f;
         valid_d    <= 1'b1;
      end
   end

   // A bubble carries ctrl_e=0 and x0 indices, so it writes nothing and matches no hazard.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd1_e      <= '0;
         rd2_e      <= '0;
         imm_ext_e  <= '0;
         pc_e       <= '0;
         pc_plus4_e <= '0;
         rs1_e      <= '0;
         rs2_e      <= '0;
         rd_e       <= '0;
         ctrl_e     <= '0;
         valid_e    <= 1'b0;
      end else if (flush_e) begin
         rd1_e      <= '0;
         rd2_e      <= '0;
         imm_ext_e  <= '0;
         pc_e       <= '0;
         pc_plus4_e <= '0;
         rs1_e      <= '0;
         rs2_e      <= '0;
         rd_e       <= '0;
         ctrl_e     <= '0;
         valid_e    <= 1'b0;
      end else begin
         rd1_e      <= rd1_d;
         rd2_e      <= rd2_d;
         imm_ext_e  <= imm_ext_d;
         pc_e       <= pc_d;
         pc_plus4_e <= pc_plus4_d;
         rs1_e      <= rs1_d;
         rs2_e      <= rs2_d;
         rd_e       <= rd_d;
         ctrl_e     <= ctrl_d;
         valid_e    <= valid_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt  <= '0;
         flush_cnt  <= '0;
         bubble_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt  <= '0;
         flush_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (stall_d && stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + CNT_ONE;
         if (flush_d && flush_cnt != CNT_MAX)
            flush_cnt <= flush_cnt + CNT_ONE;
         if (flush_e && bubble_cnt != CNT_MAX)
            bubble_cnt <= bubble_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipe_stall_flush_regs.sv
// tb/tb_pipe_stall_flush_regs.sv - scoreboard bench for pipe_stall_flush_regs
module tb_pipe_stall_flush_regs;

   localparam int F_PC = 0, F_INSTR_D = 1, F_PC_D = 2, F_PC4_D = 3, F_VALID_D = 4,
                  F_RD_E = 5, F_VALID_E = 6, F_CTRL_E = 7, F_PC_E = 8, F_IMM_E = 9,
                  F_STALL = 10, F_FLUSH = 11, F_BUBBLE = 12, F_RS1_E = 13;

   logic        clk = 1'b0;
   logic        rst, stall_f, stall_d, flush_d, flush_e, cnt_clr;
   logic [31:0] pc_next_f, instr_f, pc_plus4_f, rd1_d, rd2_d, imm_ext_d;
   logic [4:0]  rs1_d, rs2_d, rd_d;
   logic [11:0] ctrl_d;
   logic [31:0] pc_f, instr_d, pc_d, pc_plus4_d;
   logic        valid_d, valid_e;
   logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
   logic [4:0]  rs1_e, rs2_e, rd_e;
   logic [11:0] ctrl_e;
   logic [3:0]  stall_cnt, flush_cnt, bubble_cnt;

   pipe_stall_flush_regs #(.CNT_W(4)) dut (
      .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d),
      .flush_d(flush_d), .flush_e(flush_e), .pc_next_f(pc_next_f),
      .instr_f(instr_f), .pc_plus4_f(pc_plus4_f), .rd1_d(rd1_d), .rd2_d(rd2_d),
      .imm_ext_d(imm_ext_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
      .ctrl_d(ctrl_d), .cnt_clr(cnt_clr), .pc_f(pc_f), .instr_d(instr_d),
      .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .rd1_e(rd1_e),
      .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
      .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .ctrl_e(ctrl_e), .valid_e(valid_e),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   string       q_name[$];
   int          q_field[$];
   logic [31:0] q_exp[$];
   int          q_due[$];
   int          passed = 0;
   int          total  = 0;

   function automatic logic [31:0] actual(int f);
      case (f)
         F_PC:      return pc_f;
         F_INSTR_D: return instr_d;
         F_PC_D:    return pc_d;
         F_PC4_D:   return pc_plus4_d;
         F_VALID_D: return {31'b0, valid_d};
         F_RD_E:    return {27'b0, rd_e};
         F_VALID_E: return {31'b0, valid_e};
         F_CTRL_E:  return {20'b0, ctrl_e};
         F_PC_E:    return pc_e;
         F_IMM_E:   return imm_ext_e;
         F_STALL:   return {28'b0, stall_cnt};
         F_FLUSH:   return {28'b0, flush_cnt};
         F_BUBBLE:  return {28'b0, bubble_cnt};
         F_RS1_E:   return {27'b0, rs1_e};
         default:   return 32'hdead_beef;
      endcase
   endfunction

   // Expectation becomes due 'ofs' rising edges from now (0 = this cycle).
   task automatic expect_at(input string name, input int f, input logic [31:0] v, input int ofs);
      q_name.push_back(name);
      q_field.push_back(f);
      q_exp.push_back(v);
      q_due.push_back(cyc + ofs);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      while (q_due.size() > 0 && q_due[0] <= cyc) begin
         logic [31:0] a;
         a = actual(q_field[0]);
         total = total + 1;
         if (a === q_exp[0])
            passed = passed + 1;
         else
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", q_name[0], a, q_exp[0], cyc);
         void'(q_name.pop_front());
         void'(q_field.pop_front());
         void'(q_exp.pop_front());
         void'(q_due.pop_front());
      end
   end

   initial begin
      rst = 1'b1; stall_f = 0; stall_d = 0; flush_d = 0; flush_e = 0; cnt_clr = 0;
      pc_next_f = 0; instr_f = 0; pc_plus4_f = 0; rd1_d = 0; rd2_d = 0; imm_ext_d = 0;
      rs1_d = 0; rs2_d = 0; rd_d = 0; ctrl_d = 0;
      step();
      // Test 1: build some state, then assert reset mid-run
      rst = 0; pc_next_f = 32'h40; stall_d = 1; flush_e = 1;
      expect_at("pre_rst_pc", F_PC, 32'h40, 1);
      expect_at("pre_rst_stall", F_STALL, 1, 1);
      step();
      stall_d = 0; flush_e = 0;
      step();
      rst = 1;
      expect_at("rst_pc", F_PC, 32'h0, 0);
      expect_at("rst_instr_d", F_INSTR_D, 32'h0000_0013, 0);
      expect_at("rst_valid_d", F_VALID_D, 0, 0);
      expect_at("rst_valid_e", F_VALID_E, 0, 0);
      expect_at("rst_stall_cnt", F_STALL, 0, 0);
      expect_at("rst_bubble_cnt", F_BUBBLE, 0, 0);
      step();
      rst = 0; pc_next_f = 32'h4;
      expect_at("post_rst_pc", F_PC, 32'h4, 1);
      step();
      // Test 2: straight-line flow through IF/ID and ID/EX
      pc_next_f = 32'h8;
      step();
      instr_f = 32'h0050_0093; pc_plus4_f = 32'hC; pc_next_f = 32'hC;
      expect_at("sl_instr_d", F_INSTR_D, 32'h0050_0093, 1);
      expect_at("sl_pc_d", F_PC_D, 32'h8, 1);
      expect_at("sl_pc4_d", F_PC4_D, 32'hC, 1);
      expect_at("sl_valid_d", F_VALID_D, 1, 1);
      step();
      rd_d = 5'd1; rs1_d = 5'd0; ctrl_d = 12'hA5C; imm_ext_d = 32'h5;
      instr_f = 32'h00a0_0113; pc_plus4_f = 32'h10; pc_next_f = 32'h10;
      expect_at("sl_rd_e", F_RD_E, 1, 1);
      expect_at("sl_valid_e", F_VALID_E, 1, 1);
      expect_at("sl_ctrl_e", F_CTRL_E, 32'hA5C, 1);
      expect_at("sl_pc_e", F_PC_E, 32'h8, 1);
      expect_at("sl_imm_e", F_IMM_E, 32'h5, 1);
      step();
      // Test 3: load-use stall with ID/EX bubble
      stall_f = 1; stall_d = 1; flush_e = 1; pc_next_f = 32'h14;
      rd_d = 5'd2; rs1_d = 5'd1; ctrl_d = 12'h3C1;
      instr_f = 32'h0000_0033; pc_plus4_f = 32'h14;
      expect_at("lu_pc_hold", F_PC, 32'h10, 1);
      expect_at("lu_instr_hold", F_INSTR_D, 32'h00a0_0113, 1);
      expect_at("lu_ctrl_e", F_CTRL_E, 0, 1);
      expect_at("lu_rd_e", F_RD_E, 0, 1);
      expect_at("lu_rs1_e", F_RS1_E, 0, 1);
      expect_at("lu_valid_e", F_VALID_E, 0, 1);
      expect_at("lu_stall_cnt", F_STALL, 1, 1);
      expect_at("lu_bubble_cnt", F_BUBBLE, 1, 1);
      step();
      stall_f = 0; stall_d = 0; flush_e = 0;
      expect_at("lu_rel_rd_e", F_RD_E, 2, 1);
      expect_at("lu_rel_ctrl_e", F_CTRL_E, 32'h3C1, 1);
      expect_at("lu_rel_pc_e", F_PC_E, 32'hC, 1);
      expect_at("lu_rel_valid_e", F_VALID_E, 1, 1);
      expect_at("lu_rel_pc", F_PC, 32'h14, 1);
      step();
      // Test 4: taken branch
      flush_d = 1; flush_e = 1; pc_next_f = 32'h100;
      expect_at("br_pc", F_PC, 32'h100, 1);
      expect_at("br_instr_d", F_INSTR_D, 32'h0000_0013, 1);
      expect_at("br_pc_d", F_PC_D, 0, 1);
      expect_at("br_valid_d", F_VALID_D, 0, 1);
      expect_at("br_valid_e", F_VALID_E, 0, 1);
      expect_at("br_flush_cnt", F_FLUSH, 1, 1);
      expect_at("br_bubble_cnt", F_BUBBLE, 2, 1);
      step();
      // Test 5: flush_d beats stall_d
      flush_d = 0; flush_e = 0; instr_f = 32'h0020_8233; pc_next_f = 32'h104; pc_plus4_f = 32'h104;
      expect_at("pr_load_valid_d", F_VALID_D, 1, 1);
      step();
      stall_f = 1; stall_d = 1; flush_d = 1;
      expect_at("pr_instr_d", F_INSTR_D, 32'h0000_0013, 1);
      expect_at("pr_valid_d", F_VALID_D, 0, 1);
      expect_at("pr_pc", F_PC, 32'h104, 1);
      expect_at("pr_valid_e", F_VALID_E, 1, 1);
      expect_at("pr_stall_cnt", F_STALL, 2, 1);
      expect_at("pr_flush_cnt", F_FLUSH, 2, 1);
      step();
      // Test 6: saturation at 15 with 4-bit counters, then clear
      stall_f = 0; flush_d = 0; instr_f = 32'h1234_5678;
      for (int k = 1; k <= 20; k++) begin
         if (k == 5)  expect_at("sat_k5", F_STALL, 7, 1);
         if (k == 13) expect_at("sat_k13", F_STALL, 15, 1);
         if (k == 20) expect_at("sat_k20", F_STALL, 15, 1);
         if (k == 20) expect_at("sat_instr_hold", F_INSTR_D, 32'h0000_0013, 1);
         step();
      end
      cnt_clr = 1;
      expect_at("clr_stall", F_STALL, 0, 1);
      expect_at("clr_flush", F_FLUSH, 0, 1);
      expect_at("clr_bubble", F_BUBBLE, 0, 1);
      step();
      cnt_clr = 0;
      expect_at("clr_next_stall", F_STALL, 1, 1);
      step();
      stall_d = 0;
      for (int w = 0; w < 20 && q_due.size() > 0; w++) @(negedge clk);
      #1;
      if (q_due.size() > 0) begin
         $display("FAIL drain: %0d checks left unchecked, expected 0", q_due.size());
         total = total + q_due.size();
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pipe_stall_flush_regs.md
Name: pipe_stall_flush_regs

Overview:
- Consumer end of the hazard-control interface: holds the PC register, the IF/ID pipeline register and the ID/EX pipeline register of the 5-stage RV32I core.
- Applies stall_f/stall_d/flush_d/flush_e and exports rs1_e/rs2_e/rd_e back to the hazard unit.
- Keeps saturating stall/flush/bubble event counters for performance debug.

Parameters:
XLEN, 32, datapath width
CTRL_W, 12, width of packed decode control bundle (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUCtrl, ALUSrc)
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0013, instruction injected into IF/ID on flush (addi x0,x0,0)
CNT_W, 16, event counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
stall_f  in  1  hold PC
stall_d  in  1  hold IF/ID
flush_d  in  1  bubble IF/ID
flush_e  in  1  bubble ID/EX
pc_next_f  in  XLEN  next PC from PC mux
instr_f  in  32  fetched instruction
pc_plus4_f  in  XLEN  PC+4 from fetch
rd1_d, rd2_d  in  XLEN  register file read data
imm_ext_d  in  XLEN  extended immediate
rs1_d, rs2_d, rd_d  in  5  decoded register indices
ctrl_d  in  CTRL_W  decoded control bundle
cnt_clr  in  1  synchronous clear of all counters
pc_f  out  XLEN  current fetch PC
instr_d, pc_d, pc_plus4_d  out  32/XLEN/XLEN  IF/ID contents
valid_d  out  1  IF/ID holds a real instruction
rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e  out  XLEN  ID/EX datapath contents
rs1_e, rs2_e, rd_e  out  5  ID/EX indices (to hazard unit)
ctrl_e  out  CTRL_W  ID/EX control bundle
valid_e  out  1  ID/EX holds a real instruction
stall_cnt, flush_cnt, bubble_cnt  out  CNT_W  event counters

Behaviour:
- Reset (async, any cycle incl. mid-stall): pc_f=RESET_PC; instr_d=NOP_INSTR; valid_d=0; pc_d=pc_plus4_d=0; all ID/EX outputs 0, valid_e=0; counters 0. First rising edge after rst deassert: normal update.
- PC: stall_f=1 holds pc_f; otherwise pc_f<=pc_next_f. Latency 1 cycle.
- IF/ID priority: flush_d > stall_d > load.
  - flush_d: instr_d=NOP_INSTR, pc_d=pc_plus4_d=0, valid_d=0.
  - stall_d only: all IF/ID regs unchanged.
  - Load: instr_d<=instr_f, pc_d<=pc_f, pc_plus4_d<=pc_plus4_f, valid_d<=1.
- ID/EX: no stall input; priority flush_e > load.
  - flush_e: ctrl_e=0, rs1_e=rs2_e=rd_e=0, valid_e=0; data regs zeroed.
  - Load: all *_e <= *_d (pc_e<=pc_d), valid_e<=valid_d.
- Load-use case (stall_f=stall_d=flush_e=1): PC and IF/ID hold, ID/EX bubbles; the instruction in decode re-enters EX on the next unstalled cycle.
- Branch case (flush_d=flush_e=1, stalls 0): PC loads target; IF/ID and ID/EX both bubble.
- stall_d=1 with flush_d=1: flush wins, valid_d=0.
- Counters, per rising edge: cnt_clr=1 zeroes all, overriding increment that cycle. Otherwise:
  - stall_cnt +1 if stall_d.
  - flush_cnt +1 if flush_d.
  - bubble_cnt +1 if flush_e.
  - Each saturates at 2^CNT_W-1; no wrap.
- ctrl_e=0 guarantees bubbles never write registers or memory. Zeroed rd_e/rs*_e suppress forwarding and load-use matches on x0.
- No combinational paths from inputs to outputs; every output is a flop.

Test Plan:
1. Assert rst mid-run with pc_f=0x40 -> same-cycle pc_f=0, instr_d=0x00000013, valid_d=valid_e=0, counters 0. Deassert with pc_next_f=4 -> next edge pc_f=4.
2. Straight-line: instr_f=0x00500093 at pc 0x8 -> next edge instr_d=0x00500093, pc_d=8, valid_d=1. Following edge rd_e=1, valid_e=1, ctrl_e=ctrl_d.
3. Load-use: stall_f=stall_d=flush_e=1 for 1 cycle -> pc_f and instr_d unchanged, ctrl_e=0, rd_e=0, valid_e=0, stall_cnt=1, bubble_cnt=1. Release -> held instruction enters EX.
4. Branch taken: flush_d=flush_e=1, pc_next_f=0x100 -> pc_f=0x100, instr_d=NOP, valid_d=0, valid_e=0, flush_cnt=1.
5. Priority: stall_d=1 and flush_d=1 together -> instr_d=NOP, valid_d=0 (not held).
6. CNT_W=4: hold stall_d=1 for 20 cycles -> stall_cnt stops at 15. cnt_clr with stall_d=1 -> 0 that edge, 1 the next.
